// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, arbiter FSM states and the
// issue-counter width.
package alu_pkg;

  localparam int ALU_CTR_W = 12;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_XOR = 4'd1,
    OP_OR  = 4'd2,
    OP_LSL = 4'd3,
    OP_LSR = 4'd4,
    OP_ADD = 4'd5,
    OP_SUB = 4'd6,
    OP_LT  = 4'd7,
    OP_GT  = 4'd8,
    OP_EQ  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Only shifts and add/sub produce a meaningful carry; other ops leave it undefined.
  function automatic logic op_has_carry(input logic [3:0] op);
    return (op >= 4'(OP_LSL)) && (op <= 4'(OP_SUB));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant from a request vector. Round-robin from ptr by default;
// lowest index wins when ALU_ARB_FIXED_PRIO_EN is defined (no ptr port then).
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  grant
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = req & (~req + ONE);
`else
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] req_hi;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
  assign mask   = {NREQ{1'b1}} << ptr;
  assign req_hi = req & mask;
  assign grant  = (|req_hi) ? (req_hi & (~req_hi + ONE)) : (req & (~req + ONE));
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CTR_W = ALU_CTR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][3:0]  req_op,
  input  logic [NREQ-1:0][7:0]  req_a,
  input  logic [NREQ-1:0][7:0]  req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [7:0]            rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_flag,
  output logic [3:0]            alu_op,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  output logic [CTR_W-1:0]      alu_ctr,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_cout,
  input  logic                  alu_flag,
  output arb_state_t            dbg_state
);

  // Handshakes: a request transfers on the edge ending an IDLE cycle with its
  // req_valid high; req_ready is the registered one-cycle echo of that accept.
  // A response transfers on the edge where rsp_valid[g] and rsp_ready[g] are both high.

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant, grant_q;
  logic            accept, rsp_done;
  logic [3:0]      sel_op;
  logic [7:0]      sel_a, sel_b;
  logic            sel_cin;

`ifdef ALU_ARB_FIXED_PRIO_EN
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .grant (grant)
  );
`else
  localparam int PTR_W = $clog2(NREQ);
  logic [PTR_W-1:0] ptr_q, gidx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gidx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (rsp_done) begin
      ptr_q <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
    end
  end
`endif

  assign accept    = (state_q == IDLE) && (|req_valid);
  assign rsp_done  = (state_q == RESP) && (|(rsp_ready & grant_q));
  assign dbg_state = state_q;

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op[i];
        sel_a   = req_a[i];
        sel_b   = req_b[i];
        sel_cin = req_cin[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs and the counter change only on accept, so the ALU sees a new
  // counter value exactly once per issued operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_flag  <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_ctr   <= '0;
    end else begin
      req_ready <= '0;
      if (accept) begin
        grant_q   <= grant;
        req_ready <= grant;
        alu_op    <= sel_op;
        alu_a     <= sel_a;
        alu_b     <= sel_b;
        alu_cin   <= sel_cin;
        alu_ctr   <= alu_ctr + CTR_W'(1);
      end
      if (state_q == EXEC) begin
        rsp_valid <= grant_q;
        rsp_data  <= alu_rslt;
        rsp_flag  <= alu_flag;
        rsp_carry <= op_has_carry(alu_op) ? alu_cout : 1'b0;
      end
      if (rsp_done) begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a response scoreboard.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ  = 2;
  localparam int CTR_W = ALU_CTR_W;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0][3:0] req_op;
  logic [NREQ-1:0][7:0] req_a;
  logic [NREQ-1:0][7:0] req_b;
  logic [NREQ-1:0]      req_cin;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [7:0]           rsp_data;
  logic                 rsp_carry;
  logic                 rsp_flag;
  logic [3:0]           alu_op;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic                 alu_cin;
  logic [CTR_W-1:0]     alu_ctr;
  logic [7:0]           alu_rslt;
  logic                 alu_cout;
  logic                 alu_flag;
  arb_state_t           dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard entry: {grant index[1:0], flag, carry, data[7:0]}
  logic [11:0]      exp_q[$];
  int               grant_log[$];
  int               resp_cnt;
  logic [7:0]       last_data;
  logic             last_carry;
  logic             last_flag;
  int               m_ptr;
  logic [CTR_W-1:0] exp_ctr;
  logic [NREQ-1:0]  prev_valid;
  logic             lat_pend;
  logic [NREQ-1:0]  lat_g;

  alu_arbiter #(.NREQ(NREQ), .CTR_W(CTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_flag  (rsp_flag),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_ctr   (alu_ctr),
    .alu_rslt  (alu_rslt),
    .alu_cout  (alu_cout),
    .alu_flag  (alu_flag),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model ----------------
  // Returns {flag, cout, rslt}. Non-carry ops drive cout=1 as stand-in for garbage.
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    logic [7:0] r;
    logic       c;
    logic       f;
    logic [8:0] s;
    r = '0; c = 1'b1; f = 1'b0; s = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a ^ b;
      4'd2: r = a | b;
      4'd3: {c, r} = {a, cin};
      4'd4: {r, c} = {cin, a};
      4'd5: begin s = {1'b0, a} + {1'b0, b}; {c, r} = s; end
      4'd6: begin s = {1'b0, a} - {1'b0, b}; {c, r} = s; end
      4'd7: f = (a < b);
      4'd8: f = (a > b);
      4'd9: f = (a == b);
      default: r = '0;
    endcase
    return {f, c, r};
  endfunction

  function automatic logic [9:0] exp_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    logic [9:0] v;
    v = alu_fn(op, a, b, cin);
    if (!(op >= 4'd3 && op <= 4'd6)) v[8] = 1'b0;
    return v;
  endfunction

  assign {alu_flag, alu_cout, alu_rslt} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

  function automatic int winner(input logic [NREQ-1:0] v, input int ptr);
    int w;
    w = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) w = i;
`else
    for (int i = NREQ - 1; i >= 0; i--) if (v[(ptr + i) % NREQ]) w = (ptr + i) % NREQ;
`endif
    return w;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_rsp"}, {req_ready, rsp_valid, rsp_data, rsp_carry, rsp_flag}, 32'd0);
    chk({pfx, "_alu"}, {alu_op, alu_a, alu_b, alu_cin}, 32'd0);
    chk({pfx, "_ctr"}, alu_ctr, 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input int r, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cin);
    int n;
    req_op[r]    = op;
    req_a[r]     = a;
    req_b[r]     = b;
    req_cin[r]   = cin;
    req_valid[r] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 200);
    chk($sformatf("ack%0d", r), req_ready[r], 1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [NREQ-1:0] oh;
    logic [9:0]      r;
    logic [11:0]     e;
    int              gi;
    resp_cnt = 0; m_ptr = 0; exp_ctr = '0; prev_valid = '0; lat_pend = 1'b0; lat_g = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_ptr = 0; exp_ctr = '0; prev_valid = '0; lat_pend = 1'b0;
      end else begin
        if (lat_pend) begin
          chk("rsp_lat", rsp_valid, lat_g);
          lat_pend = 1'b0;
        end
        if (req_ready != '0) begin
          gi = winner(prev_valid, m_ptr);
          oh = '0;
          oh[gi] = 1'b1;
          chk("grant", req_ready, oh);
          exp_ctr = exp_ctr + 1'b1;
          chk("ctr", alu_ctr, exp_ctr);
          chk("alu_in", {alu_op, alu_a, alu_b, alu_cin},
              {req_op[gi], req_a[gi], req_b[gi], req_cin[gi]});
          r = exp_fn(req_op[gi], req_a[gi], req_b[gi], req_cin[gi]);
          exp_q.push_back({2'(gi), r});
          grant_log.push_back(gi);
          lat_pend = 1'b1;
          lat_g = oh;
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexp", rsp_valid, 0);
          end else begin
            e = exp_q.pop_front();
            oh = '0;
            oh[e[11:10]] = 1'b1;
            chk("rsp_g", rsp_valid, oh);
            chk("rsp_data", rsp_data, e[7:0]);
            chk("rsp_carry", rsp_carry, e[8]);
            chk("rsp_flag", rsp_flag, e[9]);
            m_ptr = (int'(e[11:10]) + 1) % NREQ;
          end
          last_data  = rsp_data;
          last_carry = rsp_carry;
          last_flag  = rsp_flag;
          resp_cnt++;
        end
        prev_valid = req_valid;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int s;
    int exp_seq[4];
    logic [NREQ-1:0] acc;
    int n;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{1, 0, 1, 0};
`endif
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_cin = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single request
    issue(0, 4'(OP_ADD), 8'h05, 8'h03, 1'b0);
    chk("single_ctr", alu_ctr, 1);
    drain();
    chk("single_data", last_data, 8'h08);
    chk("single_carry", last_carry, 0);

    // both requesters continuously valid
    s = grant_log.size();
    fork
      begin
        for (int k = 0; k < 3; k++)
          issue(0, 4'($urandom_range(0, 9)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int k = 0; k < 3; k++)
          issue(1, 4'($urandom_range(0, 9)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
    join
    drain();
    for (int i = 0; i < 4; i++) chk($sformatf("rr_seq%0d", i), grant_log[s + i], exp_seq[i]);

    // backpressure on requester 1; rsp_ready[0] high must not matter
    rsp_ready = 2'b01;
    issue(1, 4'(OP_XOR), 8'hF0, 8'h3C, 1'b0);
    fork
      issue(0, 4'(OP_OR), 8'h12, 8'h34, 1'b0);
    join_none
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", rsp_data, 8'hCC);
      chk("bp_valid", rsp_valid, 2'b10);
      chk("bp_nogrant", req_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 2'b11;
    wait fork;
    drain();
    chk("bp_after", last_data, 8'h36);

    // carry masking and flag
    issue(0, 4'(OP_LSL), 8'h81, 8'h00, 1'b1);
    drain();
    chk("lsl_data", last_data, 8'h03);
    chk("lsl_carry", last_carry, 1);
    issue(0, 4'(OP_AND), 8'hFF, 8'h0F, 1'b0);
    drain();
    chk("and_data", last_data, 8'h0F);
    chk("and_carry", last_carry, 0);
    issue(0, 4'(OP_EQ), 8'h42, 8'h42, 1'b0);
    drain();
    chk("eq_flag", last_flag, 1);

    // reset during EXEC
    req_op[0] = 4'(OP_SUB); req_a[0] = 8'h10; req_b[0] = 8'h20; req_cin[0] = 1'b0;
    req_valid[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[0] && n < 50);
    chk("mid_ack", req_ready[0], 1);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc = '0;
    repeat (6) begin
      @(negedge clk);
      acc = acc | rsp_valid;
    end
    chk("mid_rst_norsp", acc, 0);

    // counter wrap
    @(posedge clk);
    #1;
    for (int k = 0; k < 4095; k++)
      issue(0, 4'($urandom_range(0, 9)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain();
    chk("pre_wrap", alu_ctr, 4095);
    issue(0, 4'(OP_ADD), 8'hFF, 8'h01, 1'b0);
    chk("wrap_ctr", alu_ctr, 0);
    drain();
    chk("wrap_data", last_data, 8'h00);
    chk("wrap_carry", last_carry, 1);

    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
